// File: rtl/i2c_ctrl_pkg.sv
// Shared types for the byte-level I2C master: command encodings, FSM states,
// quarter-period index and the default SCL divider.
package i2c_ctrl_pkg;

   localparam int unsigned CLK_DIV_DEFAULT = 250;

   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_STOP  = 2'd1,
      OP_WRITE = 2'd2,
      OP_READ  = 2'd3
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BITS,
      ST_ACK,
      ST_STOP,
      ST_RESP
   } state_e;

   typedef logic [1:0] qtr_t;

   localparam qtr_t Q0 = 2'd0;
   localparam qtr_t Q1 = 2'd1;
   localparam qtr_t Q2 = 2'd2;
   localparam qtr_t Q3 = 2'd3;

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period timer: down-counter reloaded with CLK_DIV-1, tick on
// terminal count, plus the 2-bit index of the quarter currently running.
module i2c_qtr_tick
   import i2c_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick,
   output qtr_t qtr
);

   localparam int unsigned CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] TC_LOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= TC_LOAD;
         qtr <= Q0;
      end else if (restart) begin
         cnt <= TC_LOAD;
         qtr <= Q0;
      end else if (tick) begin
         cnt <= TC_LOAD;
         qtr <= qtr_t'(qtr + 2'd1);
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: runs START/STOP/WRITE/READ commands as quarter-timed
// SCL/SDA waveforms on an open-drain pad driver and returns one response each.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cmd_ready high, lines held (released, or SCL low if bus open)
// ST_START | one bit period generating a START or repeated START
// ST_BITS  | eight data bit periods, MSB first (write drives, read samples)
// ST_ACK   | ninth bit: slave ACK for WRITE, master ACK/NACK for READ
// ST_STOP  | one bit period generating a STOP
// ST_RESP  | one cycle publishing the response registers
module i2c_byte_master
   import i2c_ctrl_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   input  logic       cmd_nack,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_ack,
   output logic       rsp_err,
   output logic       bus_open,
   output logic       SDAi,
   output logic       SDAt,
   input  logic       SDAo,
   output logic       SCLi,
   output logic       SCLt
);

   state_e     state;
   cmd_op_e    op_r;
   cmd_op_e    op_in;
   logic       nack_r;
   logic       rep_r;
   logic       err_r;
   logic       ack_r;
   logic [7:0] shreg;
   logic [2:0] bitcnt;
   logic       accept;
   logic       tick;
   qtr_t       qtr;

   assign SDAi   = 1'b0;
   assign SCLi   = 1'b0;
   assign op_in  = cmd_op_e'(cmd_op);
   assign accept = cmd_valid & cmd_ready;

   i2c_qtr_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_qtr_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (accept),
      .tick    (tick),
      .qtr     (qtr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
         rsp_ack   <= 1'b0;
         rsp_err   <= 1'b0;
         bus_open  <= 1'b0;
         SDAt      <= 1'b1;
         SCLt      <= 1'b1;
         op_r      <= OP_START;
         nack_r    <= 1'b0;
         rep_r     <= 1'b0;
         err_r     <= 1'b0;
         ack_r     <= 1'b0;
         shreg     <= 8'h00;
         bitcnt    <= 3'd0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cmd_ready <= 1'b0;
                  op_r      <= op_in;
                  nack_r    <= cmd_nack;
                  shreg     <= cmd_data;
                  bitcnt    <= 3'd7;
                  rep_r     <= bus_open;
                  err_r     <= 1'b0;
                  ack_r     <= 1'b0;
                  // Anything but START on a closed bus is refused without touching the lines.
                  if (op_in != OP_START && !bus_open) begin
                     err_r <= 1'b1;
                     state <= ST_RESP;
                  end else begin
                     case (op_in)
                        OP_START: begin
                           state <= ST_START;
                           SDAt  <= 1'b1;
                           if (bus_open) SCLt <= 1'b0;
                        end
                        OP_STOP: begin
                           state <= ST_STOP;
                           SDAt  <= 1'b0;
                           SCLt  <= 1'b0;
                        end
                        OP_WRITE: begin
                           state <= ST_BITS;
                           SDAt  <= cmd_data[7];
                           SCLt  <= 1'b0;
                        end
                        default: begin
                           state <= ST_BITS;
                           SDAt  <= 1'b1;
                           SCLt  <= 1'b0;
                        end
                     endcase
                  end
               end
            end
            ST_START: begin
               if (tick) begin
                  case (qtr)
                     Q0: if (rep_r) SCLt <= 1'b1; else SDAt <= 1'b0;
                     Q1: if (rep_r) SDAt <= 1'b0;
                     Q2: SCLt <= 1'b0;
                     default: begin
                        bus_open <= 1'b1;
                        state    <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_BITS: begin
               if (tick) begin
                  case (qtr)
                     Q0: SCLt <= 1'b1;
                     Q1: begin
                     end
                     Q2: begin
                        SCLt <= 1'b0;
                        if (op_r == OP_READ) shreg <= {shreg[6:0], SDAo};
                     end
                     default: begin
                        if (bitcnt == 3'd0) begin
                           state <= ST_ACK;
                           SDAt  <= (op_r == OP_READ) ? nack_r : 1'b1;
                        end else begin
                           bitcnt <= bitcnt - 3'd1;
                           if (op_r == OP_WRITE) begin
                              shreg <= {shreg[6:0], 1'b0};
                              SDAt  <= shreg[6];
                           end
                        end
                     end
                  endcase
               end
            end
            ST_ACK: begin
               if (tick) begin
                  case (qtr)
                     Q0: SCLt <= 1'b1;
                     Q1: begin
                     end
                     Q2: begin
                        SCLt <= 1'b0;
                        if (op_r == OP_WRITE) ack_r <= ~SDAo;
                     end
                     default: state <= ST_RESP;
                  endcase
               end
            end
            ST_STOP: begin
               if (tick) begin
                  case (qtr)
                     Q0: SCLt <= 1'b1;
                     Q1: SDAt <= 1'b1;
                     Q2: begin
                     end
                     default: begin
                        bus_open <= 1'b0;
                        state    <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_RESP: begin
               rsp_valid <= 1'b1;
               cmd_ready <= 1'b1;
               rsp_err   <= err_r;
               rsp_ack   <= ack_r;
               if (op_r == OP_READ && !err_r) rsp_data <= shreg;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Byte-level I2C master controller that sequences the SDA/SCL pad driver.
- Accepts START / STOP / WRITE / READ commands over a valid/ready handshake.
- Generates bit-accurate SCL/SDA waveforms and returns one response per command.
- Sits between the slow-control register logic and the I2C pad driver: SDA is open-drain via its tristate; SCL is released-high/driven-low via its SCLi|SCLt combination.

## Interface
Parameters:
- CLK_DIV, 250: clk cycles per SCL quarter-period (100 kHz SCL at 100 MHz clk). Legal range 4..65535.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset; one clock domain, no other resets.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  0=START, 1=STOP, 2=WRITE, 3=READ.
- cmd_data  in  8  byte to transmit; WRITE only, MSB first.
- cmd_nack  in  1  READ only: 1 sends NACK, 0 sends ACK.
- rsp_valid  out  1  one-cycle pulse on command completion.
- rsp_data  out  8  byte received by READ; holds its value otherwise.
- rsp_ack  out  1  WRITE: 1 if slave ACKed (SDA sampled low); 0 for all other ops.
- rsp_err  out  1  1 if the command was rejected (see Operation).
- bus_open  out  1  START issued, STOP not yet completed.
- SDAi  out  1  SDA drive value to the pad driver; constant 0.
- SDAt  out  1  SDA tristate: 1 releases the line (high), 0 pulls it low.
- SDAo  in  1  SDA pad readback.
- SCLi  out  1  SCL drive value; constant 0.
- SCLt  out  1  1 puts SCL high, 0 puts it low.

## Operation
- Reset values:
  - SDAt=1, SCLt=1, SDAi=0, SCLi=0.
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_ack=0, rsp_err=0, bus_open=0.
- Reset asserted mid-command releases both lines on the next state update. No STOP is generated; recovery is the host's job (START then STOP).
- States: IDLE, START, BITS, ACK, STOP, RESP.
- cmd_ready=1 only in IDLE. A command is accepted on a clk edge with cmd_valid&cmd_ready; cmd_op, cmd_data and cmd_nack are registered at that edge.
- Each SCL bit period is four quarters Q0..Q3 of CLK_DIV cycles. The divider restarts at 0 on command acceptance.
- START from SCL high (bus_open=0):
  - Q0: SDA released.
  - Q1: SDA low.
  - Q2: hold.
  - Q3: SCL low.
- START with bus_open=1 (repeated START):
  - Q0: SDA released, SCL low.
  - Q1: SCL high.
  - Q2: SDA low.
  - Q3: SCL low.
- START sets bus_open.
- WRITE:
  - 8 data bits MSB first, then one ACK bit.
  - Per bit: Q0 set SDA with SCL low, Q1 SCL high, Q2 SCL high, Q3 SCL low.
  - During the ACK bit SDA is released; SDAo is sampled at the last cycle of Q2; rsp_ack = ~SDAo.
- READ:
  - SDA released for 8 bits; SDAo is sampled at the last cycle of Q2 and shifted in MSB first.
  - 9th bit: SDAt = cmd_nack.
  - rsp_data is updated when rsp_valid fires.
- STOP:
  - Q0: SDA low, SCL low.
  - Q1: SCL high.
  - Q2: SDA released.
  - Q3: hold.
  - Clears bus_open at completion.
- Rejection: STOP, WRITE or READ accepted while bus_open=0 causes no bus activity. rsp_valid fires on the next cycle with rsp_err=1, rsp_ack=0.
- Between commands with bus_open=1, SCL stays low and SDA holds its last value.

## Timing
- START, STOP: rsp_valid asserted 4·CLK_DIV+1 cycles after the accept edge.
- WRITE, READ: rsp_valid asserted 36·CLK_DIV+1 cycles after the accept edge.
- Rejected command: rsp_valid asserted 1 cycle after the accept edge.
- rsp_valid lasts one cycle. cmd_ready rises in the same cycle, so back-to-back commands have 1 idle cycle.
- Line outputs are registered and change only at quarter boundaries.
- cmd_valid held during a busy period has no effect until cmd_ready is high.

## Structure
- Package i2c_ctrl_pkg: cmd_op encodings, state enum, quarter index type, default CLK_DIV.
- Sub-module i2c_qtr_tick: CLK_DIV counter with synchronous restart; emits a one-cycle quarter tick and the 2-bit quarter index.
- Top level holds the FSM, 3-bit bit counter, shift register and response registers.

## Test plan
CLK_DIV=4 throughout, with a behavioural slave model on SDA.
- Reset released, no commands -> SDAt=1, SCLt=1, cmd_ready=1, bus_open=0 indefinitely.
- START from idle -> SDAt falls 4 cycles after accept, SCLt falls 12 cycles after accept, rsp_valid at +17, bus_open=1.
- WRITE 0xA5 with slave ACK -> SDAt sequence 1,0,1,0,0,1,0,1 sampled on SCLt high; rsp_ack=1 at +145. Repeated with slave not ACKing -> rsp_ack=0.
- READ with slave sending 0x3C, cmd_nack=1 -> rsp_data=0x3C, SDAt=1 during the 9th bit. Repeated with cmd_nack=0 -> SDAt=0 during the 9th bit.
- Repeated START after a WRITE, then STOP -> SDA falls while SCL high; STOP ends with SCLt=1, SDAt=1, bus_open=0.
- READ with bus_open=0 -> rsp_err=1 on the next cycle, no SCLt toggle.
- rst_n pulsed mid-WRITE -> SDAt=1, SCLt=1, bus_open=0, cmd_ready=1.
